// File: rtl/nn_ctrl_pkg.sv
// Shared types and sizing helpers for the u-law MNIST sequencing controller.
package nn_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    L1_ARG,
    L1_LD,
    L1_TEST,
    L1_W,
    L1_WD,
    L1_MAC,
    L2_W,
    L2_WD,
    L2_LUT,
    L2_MAC,
    O_LUT,
    O_SH,
    DONE
  } nn_state_e;

  localparam int N_IN_DEF  = 785;
  localparam int N_HID_DEF = 25;
  localparam int N_OUT_DEF = 10;

  localparam logic [7:0] ULAW_ZERO = 8'hFF;

  // Width of a counter holding values 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int I_W_DEF = cnt_w(N_IN_DEF);
  localparam int J_W_DEF = cnt_w(N_HID_DEF + 1);
  localparam int P_W_DEF = cnt_w(N_OUT_DEF);

endpackage

// File: rtl/nn_stream_rd.sv
// Streams COUNT consecutive reads from base_i while en_i is high; the shift
// enable trails each read by one cycle, matching the memory read latency.
module nn_stream_rd
  import nn_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int COUNT      = N_HID_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rd_o,
  output logic                  sh_en_o,
  output logic                  last_o
);

  localparam int KW = cnt_w(COUNT);

  logic [KW-1:0] k_q, k_d;
  logic          sh_q;

  assign rd_o    = en_i;
  assign addr_o  = base_i + ADDR_WIDTH'(k_q);
  assign last_o  = en_i && (k_q == KW'(COUNT - 1));
  assign sh_en_o = sh_q;

  always_comb begin
    k_d = k_q;
    if (en_i) k_d = last_o ? '0 : k_q + KW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q  <= '0;
      sh_q <= 1'b0;
    end else begin
      k_q  <= k_d;
      sh_q <= en_i;
    end
  end

endmodule

// File: rtl/nn_seq_ctrl_ulaw.sv
// Inference sequencer: clear, layer-1 MAC, layer-2 MAC, sigmoid readout.
// Define NN_ZERO_SKIP_EN to skip weight loads for u-law zero arguments.
module nn_seq_ctrl_ulaw
  import nn_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int N_IN       = N_IN_DEF,
  parameter int N_HID      = N_HID_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int IMG_BASE   = 0,
  parameter int W1_BASE    = 1024,
  parameter int W2_BASE    = 20736,
  parameter int LUT_BASE   = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  arg_zero,
  input  logic [ADDR_WIDTH-1:0] lut_idx,
  output logic [3:0]            r_sh_en,
  output logic [1:0]            mac_en,
  output logic [1:0]            mac_clr,
  output logic [ADDR_WIDTH-1:0] lut_pos,
  output logic                  lut_sel
);

  localparam int IW = cnt_w(N_IN);
  localparam int JW = cnt_w(N_HID + 1);
  localparam int PW = cnt_w(N_OUT);

  nn_state_e       state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [PW-1:0]   p_q, p_d;

  logic [ADDR_WIDTH-1:0] w1_base, w2_base, w1_addr, w2_addr;
  logic                  w1_rd, w2_rd, w1_sh, w2_sh, w1_last, w2_last;
  logic                  skip_arg, i_last;

`ifdef NN_ZERO_SKIP_EN
  assign skip_arg = arg_zero;
`else
  logic unused_arg_zero;
  assign unused_arg_zero = arg_zero;
  assign skip_arg        = 1'b0;
`endif

  assign i_last  = (i_q == IW'(N_IN - 1));
  assign w1_base = ADDR_WIDTH'(W1_BASE) + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(N_HID);
  assign w2_base = ADDR_WIDTH'(W2_BASE) + ADDR_WIDTH'(j_q) * ADDR_WIDTH'(N_OUT);

  nn_stream_rd #(.ADDR_WIDTH(ADDR_WIDTH), .COUNT(N_HID)) u_w1_stream (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (state_q == L1_W),
    .base_i  (w1_base),
    .addr_o  (w1_addr),
    .rd_o    (w1_rd),
    .sh_en_o (w1_sh),
    .last_o  (w1_last)
  );

  nn_stream_rd #(.ADDR_WIDTH(ADDR_WIDTH), .COUNT(N_OUT)) u_w2_stream (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (state_q == L2_W),
    .base_i  (w2_base),
    .addr_o  (w2_addr),
    .rd_o    (w2_rd),
    .sh_en_o (w2_sh),
    .last_o  (w2_last)
  );

  assign busy = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    p_d      = p_q;
    done     = 1'b0;
    mem_addr = ADDR_WIDTH'(IMG_BASE);
    mem_rd   = 1'b0;
    r_sh_en  = {1'b0, w2_sh, w1_sh, 1'b0};
    mac_en   = 2'b00;
    mac_clr  = 2'b00;
    lut_pos  = '0;
    lut_sel  = 1'b0;

    case (state_q)
      IDLE: if (start) state_d = CLR;
      CLR: begin
        mac_clr = 2'b11;
        i_d     = '0;
        state_d = L1_ARG;
      end
      L1_ARG: begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_WIDTH'(IMG_BASE) + ADDR_WIDTH'(i_q);
        state_d  = L1_LD;
      end
      L1_LD: begin
        r_sh_en[0] = 1'b1;
        state_d    = L1_TEST;
      end
      L1_TEST: begin
        if (skip_arg) begin
          state_d = i_last ? L2_W : L1_ARG;
          i_d     = i_last ? '0 : i_q + IW'(1);
          j_d     = '0;
        end else begin
          state_d = L1_W;
        end
      end
      L1_W: begin
        mem_rd   = w1_rd;
        mem_addr = w1_addr;
        if (w1_last) state_d = L1_WD;
      end
      L1_WD: state_d = L1_MAC;
      L1_MAC: begin
        mac_en  = 2'b01;
        state_d = i_last ? L2_W : L1_ARG;
        i_d     = i_last ? '0 : i_q + IW'(1);
        j_d     = '0;
      end
      L2_W: begin
        lut_pos  = ADDR_WIDTH'(j_q);
        mem_rd   = w2_rd;
        mem_addr = w2_addr;
        if (w2_last) state_d = L2_WD;
      end
      L2_WD: begin
        lut_pos = ADDR_WIDTH'(j_q);
        state_d = L2_LUT;
      end
      L2_LUT: begin
        // j=0 is the bias term: no sigmoid lookup, the MAC sees the constant.
        lut_pos = ADDR_WIDTH'(j_q);
        if (j_q != '0) begin
          mem_rd   = 1'b1;
          mem_addr = ADDR_WIDTH'(LUT_BASE) + lut_idx;
        end
        state_d = L2_MAC;
      end
      L2_MAC: begin
        lut_pos = ADDR_WIDTH'(j_q);
        mac_en  = 2'b10;
        if (j_q == JW'(N_HID)) begin
          state_d = O_LUT;
          p_d     = '0;
        end else begin
          state_d = L2_W;
          j_d     = j_q + JW'(1);
        end
      end
      O_LUT: begin
        lut_sel  = 1'b1;
        lut_pos  = ADDR_WIDTH'(p_q);
        mem_rd   = 1'b1;
        mem_addr = ADDR_WIDTH'(LUT_BASE) + lut_idx;
        state_d  = O_SH;
      end
      O_SH: begin
        lut_sel    = 1'b1;
        lut_pos    = ADDR_WIDTH'(p_q);
        r_sh_en[3] = 1'b1;
        if (p_q == PW'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          state_d = O_LUT;
          p_d     = p_q + PW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_nn_seq_ctrl_ulaw.sv
// Bench for nn_seq_ctrl_ulaw: random images against an address/timing model.
`timescale 1ns/1ps
module tb_nn_seq_ctrl_ulaw;
  import nn_ctrl_pkg::*;

  localparam int AW      = 16;
  localparam int TB_N_IN = 16;
  localparam int HID     = 25;
  localparam int OUT     = 10;
  localparam int IMGB    = 0;
  localparam int W1B     = 1024;
  localparam int W2B     = 20736;
  localparam int LUTB    = 32768;
  localparam int LUT_OFS = 40;
  localparam int LIMIT   = 5000;
`ifdef NN_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic          clk, rst, start;
  logic          busy, done, mem_rd, arg_zero, lut_sel;
  logic [AW-1:0] mem_addr, lut_idx, lut_pos;
  logic [3:0]    r_sh_en;
  logic [1:0]    mac_en, mac_clr;

  nn_seq_ctrl_ulaw #(.ADDR_WIDTH(AW), .N_IN(TB_N_IN), .N_HID(HID), .N_OUT(OUT),
                     .IMG_BASE(IMGB), .W1_BASE(W1B), .W2_BASE(W2B), .LUT_BASE(LUTB)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .arg_zero(arg_zero), .lut_idx(lut_idx),
    .r_sh_en(r_sh_en), .mac_en(mac_en), .mac_clr(mac_clr), .lut_pos(lut_pos), .lut_sel(lut_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: latch the argument read from the image, sigmoid index = pos + 40.
  logic [7:0] img [TB_N_IN];
  logic [7:0] arg_latch;
  always @(posedge clk or negedge rst) begin
    if (!rst) arg_latch <= 8'h00;
    else if (mem_rd && int'(mem_addr) < IMGB + TB_N_IN) arg_latch <= img[int'(mem_addr) - IMGB];
  end
  assign arg_zero = (arg_latch == ULAW_ZERO);
  assign lut_idx  = lut_pos + AW'(LUT_OFS);

  function automatic bit in_img(input logic [AW-1:0] a);
    return int'(a) < IMGB + TB_N_IN;
  endfunction
  function automatic bit in_w1(input logic [AW-1:0] a);
    return int'(a) >= W1B && int'(a) < W1B + TB_N_IN * HID;
  endfunction
  function automatic bit in_w2(input logic [AW-1:0] a);
    return int'(a) >= W2B && int'(a) < W2B + (HID + 1) * OUT;
  endfunction
  function automatic bit in_lut(input logic [AW-1:0] a);
    return int'(a) >= LUTB;
  endfunction

  // Monitor: logs every read and counts pulses and rule violations.
  logic [AW-1:0] rd_log [$];
  int n_busy, n_done, n_mac0, n_mac1, inv_err, sh1_run, sh2_run;
  bit prev_img, prev_w1, prev_w2, prev_o;
  logic [AW-1:0] prev_lp;
  initial begin
    n_busy = 0; n_done = 0; n_mac0 = 0; n_mac1 = 0; inv_err = 0; sh1_run = 0; sh2_run = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      prev_img = 0; prev_w1 = 0; prev_w2 = 0; prev_o = 0; prev_lp = '0; sh1_run = 0; sh2_run = 0;
    end else begin
      if (mem_rd) rd_log.push_back(mem_addr);
      if (busy) n_busy++;
      if (done) n_done++;
      if (mac_en[0]) n_mac0++;
      if (mac_en[1]) n_mac1++;
      if (mac_en == 2'b11 || (mac_en != 2'b00 && mac_clr != 2'b00)) inv_err++;
      if (r_sh_en[0] !== prev_img || r_sh_en[1] !== prev_w1 ||
          r_sh_en[2] !== prev_w2 || r_sh_en[3] !== prev_o) inv_err++;
      if ((mac_en[1] || r_sh_en[3]) && lut_pos !== prev_lp) inv_err++;
      if (r_sh_en[1]) sh1_run++;
      if (r_sh_en[2]) sh2_run++;
      if (mac_en[0]) begin if (sh1_run != HID) inv_err++; sh1_run = 0; end
      if (mac_en[1]) begin if (sh2_run != OUT) inv_err++; sh2_run = 0; end
      prev_img = mem_rd && in_img(mem_addr);
      prev_w1  = mem_rd && in_w1(mem_addr);
      prev_w2  = mem_rd && in_w2(mem_addr);
      prev_o   = mem_rd && in_lut(mem_addr) && lut_sel;
      prev_lp  = lut_pos;
    end
  end

  // Reference model: expected read-address stream and busy length from the image.
  logic [AW-1:0] exp_q [$];
  int exp_T, exp_mac0;
  task automatic build_model();
    int nz = 0, z = 0;
    exp_q.delete();
    for (int i = 0; i < TB_N_IN; i++) begin
      exp_q.push_back(AW'(IMGB + i));
      if (SKIP_EN && img[i] == ULAW_ZERO) z++;
      else begin
        nz++;
        for (int k = 0; k < HID; k++) exp_q.push_back(AW'(W1B + i * HID + k));
      end
    end
    for (int j = 0; j <= HID; j++) begin
      for (int k = 0; k < OUT; k++) exp_q.push_back(AW'(W2B + j * OUT + k));
      if (j > 0) exp_q.push_back(AW'(LUTB + j + LUT_OFS));
    end
    for (int p = 0; p < OUT; p++) exp_q.push_back(AW'(LUTB + p + LUT_OFS));
    exp_T    = 1 + 30 * nz + 3 * z + 13 * (HID + 1) + 2 * OUT;
    exp_mac0 = nz;
  endtask

  task automatic rand_img(input int zero_pct);
    for (int i = 0; i < TB_N_IN; i++)
      img[i] = ($urandom_range(99, 0) < zero_pct) ? ULAW_ZERO : 8'($urandom_range(254, 0));
  endtask

  function automatic int rd_mismatch(input int base);
    for (int n = 0; n < exp_q.size(); n++)
      if (base + n >= rd_log.size() || rd_log[base + n] !== exp_q[n]) return n;
    if (rd_log.size() - base != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  int n_tests, n_fail;
  int s_busy, s_done, s_mac0, s_mac1, s_inv, s_rd;

  task automatic snapshot();
    s_busy = n_busy; s_done = n_done; s_mac0 = n_mac0;
    s_mac1 = n_mac1; s_inv = inv_err; s_rd = rd_log.size();
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk); #1;
      if (done) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic run_inference(output bit timed_out);
    @(negedge clk); #1;
    snapshot();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(timed_out);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
    n_tests++; if (mem_addr !== AW'(IMGB)) begin n_fail++; $display("FAIL rst_mem_addr: got %0d expected %0d", mem_addr, IMGB); end
    n_tests++; if ({r_sh_en, mac_en, mac_clr} !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 00", {r_sh_en, mac_en, mac_clr}); end
    n_tests++; if ({lut_sel, lut_pos} !== 17'h0) begin n_fail++; $display("FAIL rst_lut: got %h expected 0", {lut_sel, lut_pos}); end
    @(negedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_bias_only();
    bit to; int mm;
    for (int i = 0; i < TB_N_IN; i++) img[i] = ULAW_ZERO;
    img[0] = 8'h23;
    build_model();
    run_inference(to);
    mm = rd_mismatch(s_rd);
    n_tests++; if (to) begin n_fail++; $display("FAIL bias_timeout: got no done expected done within %0d", LIMIT); end
    n_tests++; if (n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL bias_busy_len: got %0d expected %0d", n_busy - s_busy, exp_T); end
    n_tests++; if (n_done - s_done != 1) begin n_fail++; $display("FAIL bias_done_cnt: got %0d expected 1", n_done - s_done); end
    n_tests++; if (n_mac0 - s_mac0 != exp_mac0) begin n_fail++; $display("FAIL bias_mac0: got %0d expected %0d", n_mac0 - s_mac0, exp_mac0); end
    n_tests++; if (n_mac1 - s_mac1 != HID + 1) begin n_fail++; $display("FAIL bias_mac1: got %0d expected %0d", n_mac1 - s_mac1, HID + 1); end
    n_tests++; if (mm != -1) begin n_fail++; $display("FAIL bias_rd_seq: got first bad read index %0d expected none", mm); end
    n_tests++; if (inv_err - s_inv != 0) begin n_fail++; $display("FAIL bias_rules: got %0d violations expected 0", inv_err - s_inv); end
  endtask

  task automatic test_input5();
    bit to; int at, bad;
    for (int i = 0; i < TB_N_IN; i++) img[i] = ULAW_ZERO;
    img[5] = 8'h41;
    build_model();
    run_inference(to);
    at = -1;
    for (int n = s_rd; n < rd_log.size(); n++) if (rd_log[n] == AW'(1149)) begin at = n; break; end
    bad = (at < 0) ? 1 : 0;
    if (at >= 0) for (int k = 0; k < HID; k++)
      if (at + k >= rd_log.size() || rd_log[at + k] !== AW'(1149 + k)) bad = 1;
    n_tests++; if (to) begin n_fail++; $display("FAIL in5_timeout: got no done expected done within %0d", LIMIT); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL in5_w1_addrs: got start index %0d, run broken=%0d expected 1149..1173 contiguous", at, bad); end
    n_tests++; if (rd_mismatch(s_rd) != -1) begin n_fail++; $display("FAIL in5_rd_seq: got first bad index %0d expected none", rd_mismatch(s_rd)); end
    n_tests++; if (inv_err - s_inv != 0) begin n_fail++; $display("FAIL in5_shift_mac_timing: got %0d violations expected 0", inv_err - s_inv); end
    n_tests++; if (n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL in5_busy_len: got %0d expected %0d", n_busy - s_busy, exp_T); end
  endtask

  task automatic test_lut_reads();
    bit to; logic [AW-1:0] got [$]; int bad;
    rand_img(50);
    build_model();
    run_inference(to);
    for (int n = s_rd; n < rd_log.size(); n++) if (in_lut(rd_log[n])) got.push_back(rd_log[n]);
    bad = (got.size() != HID + OUT) ? 1 : 0;
    for (int n = 0; n < got.size() && n < HID + OUT; n++)
      if (got[n] !== ((n < HID) ? AW'(LUTB + LUT_OFS + 1 + n) : AW'(LUTB + LUT_OFS + n - HID))) bad = 1;
    n_tests++; if (to) begin n_fail++; $display("FAIL lut_timeout: got no done expected done within %0d", LIMIT); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL lut_addrs: got %0d LUT reads (first %0d) expected 32809..32833 then 32808..32817", got.size(), (got.size() > 0) ? int'(got[0]) : -1); end
  endtask

  task automatic test_random();
    bit to; int mm;
    for (int r = 0; r < 3; r++) begin
      rand_img(30 * r);
      img[$urandom_range(TB_N_IN - 1, 0)] = 8'h00;
      build_model();
      run_inference(to);
      mm = rd_mismatch(s_rd);
      n_tests++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: got no done expected done within %0d", r, LIMIT); end
      n_tests++; if (n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL rnd%0d_busy_len: got %0d expected %0d", r, n_busy - s_busy, exp_T); end
      n_tests++; if (n_mac0 - s_mac0 != exp_mac0) begin n_fail++; $display("FAIL rnd%0d_mac0: got %0d expected %0d", r, n_mac0 - s_mac0, exp_mac0); end
      n_tests++; if (mm != -1) begin n_fail++; $display("FAIL rnd%0d_rd_seq: got first bad index %0d expected none", r, mm); end
      n_tests++; if (inv_err - s_inv != 0) begin n_fail++; $display("FAIL rnd%0d_rules: got %0d violations expected 0", r, inv_err - s_inv); end
    end
  endtask

  task automatic test_reset_mid();
    bit to; int d0;
    rand_img(40);
    img[0] = 8'h10;
    @(negedge clk); #1;
    d0 = n_done;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < LIMIT; c++) begin
      if (mem_rd && in_w1(mem_addr)) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    n_tests++; if (to) begin n_fail++; $display("FAIL mid_reach_l1w: got no W1 read expected one within %0d", LIMIT); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if ({busy, done, mem_rd, r_sh_en, mac_en, mac_clr, lut_sel, lut_pos, mem_addr} !== {28'h0, AW'(IMGB)})
      begin n_fail++; $display("FAIL mid_rst_outputs: got %h expected all zero", {busy, done, mem_rd, r_sh_en, mac_en, mac_clr, lut_sel, lut_pos, mem_addr}); end
    @(negedge clk); #1 rst = 1'b1;
    repeat (40) @(negedge clk); #1;
    n_tests++; if (n_done - d0 != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %0d done pulses busy=%b expected 0 and 0", n_done - d0, busy); end
    build_model();
    run_inference(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL mid_rerun_timeout: got no done expected done within %0d", LIMIT); end
    n_tests++; if (n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL mid_rerun_busy: got %0d expected %0d", n_busy - s_busy, exp_T); end
    n_tests++; if (rd_mismatch(s_rd) != -1) begin n_fail++; $display("FAIL mid_rerun_rd_seq: got first bad index %0d expected none", rd_mismatch(s_rd)); end
  endtask

  task automatic test_start_held();
    bit to;
    rand_img(50);
    build_model();
    @(negedge clk); #1;
    snapshot();
    start = 1'b1;
    wait_done(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL held_timeout: got no done expected done within %0d", LIMIT); end
    n_tests++; if (n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL held_busy_len: got %0d expected %0d", n_busy - s_busy, exp_T); end
    n_tests++; if (n_done - s_done != 1) begin n_fail++; $display("FAIL held_one_run: got %0d done pulses expected 1", n_done - s_done); end
    @(negedge clk); #1;
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL held_idle_gap: got busy/done %b expected 00", {busy, done}); end
    snapshot();
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart: got busy %b expected 1", busy); end
    start = 1'b0;
    wait_done(to);
    n_tests++; if (to || n_busy - s_busy != exp_T) begin n_fail++; $display("FAIL held_second_run: got busy %0d (timeout=%0d) expected %0d", n_busy - s_busy, to, exp_T); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0;
    test_reset();
    test_bias_only();
    test_input5();
    test_lut_reads();
    test_random();
    test_reset_mid();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_seq_ctrl_ulaw.md
Name: nn_seq_ctrl_ulaw

Overview:
Sequencing controller for the u-law two-layer MNIST datapath (sigmoid/MAC stage). It drives a single-port synchronous weight/image/LUT memory and the datapath controls: r_sh_en, mac_en, mac_clr, lut_pos and lut_sel. One start pulse runs a full inference, in order:
- clear both MAC banks
- layer-1 accumulation over N_IN inputs, optionally skipping zero arguments
- layer-2 accumulation over N_HID+1 hidden terms (index 0 is the bias)
- sigmoid readout of N_OUT results into the output shift register

Parameters:
- ADDR_WIDTH, 16, memory/LUT address width
- N_IN, 785, layer-1 inputs including the bias input
- N_HID, 25, hidden neurons (equals datapath R1 depth)
- N_OUT, 10, output neurons (equals datapath R2/R3 depth)
- IMG_BASE, 0, base address of the input arguments
- W1_BASE, 1024, base address of layer-1 weights; N_HID per input, in shift order
- W2_BASE, 20736, base address of layer-2 weights; N_OUT per hidden index j=0..N_HID
- LUT_BASE, 32768, base address of the sigmoid LUT

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, begins an inference; sampled only in IDLE.
- busy, out, 1, high from the cycle after start is accepted until the last control cycle.
- done, out, 1, one-cycle pulse after the last busy cycle.
- mem_addr, out, ADDR_WIDTH, memory read address (combinational from state, counters and lut_idx).
- mem_rd, out, 1, read strobe; mem_data is valid in the following cycle.
- arg_zero, in, 1, datapath flag: the latched argument is the u-law zero code.
- lut_idx, in, ADDR_WIDTH, datapath sigmoid index for the current lut_pos/lut_sel.
- r_sh_en, out, 4, shift enables: [0]=R_ARG, [1]=R1, [2]=R2, [3]=R3.
- mac_en, out, 2, MAC enables: [0]=layer 1, [1]=layer 2.
- mac_clr, out, 2, MAC clears.
- lut_pos, out, ADDR_WIDTH, datapath LUT position.
- lut_sel, out, 1, 0 selects the layer-1 sigmoid bank, 1 selects layer 2.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, all counters 0.
  - All outputs 0. mem_addr is IMG_BASE when idle.
  - Reset mid-inference aborts immediately; no done pulse follows.
- IDLE: start=1 moves to CLR. start while busy is ignored.
- CLR (1 cycle): mac_clr=2'b11; i=0.
- Layer 1, per input i:
  - L1_ARG: mem_rd=1, mem_addr=IMG_BASE+i.
  - L1_LD: r_sh_en[0]=1.
  - L1_TEST: arg_zero is valid here. If it is 1, the input is skipped (see ZERO_SKIP_EN): i++ and go to L1_ARG, or to L2 when i=N_IN-1.
  - L1_W (N_HID cycles, k=0..N_HID-1): mem_rd=1, mem_addr=W1_BASE+i*N_HID+k.
  - r_sh_en[1] is mem_rd delayed one cycle. It is high in L1_W cycles 2..N_HID and in L1_WD.
  - L1_WD (1 cycle): final shift only.
  - L1_MAC (1 cycle): mac_en[0]=1; then i++ and branch as in L1_TEST.
  - Cost: 30 cycles per loaded input, 3 per skipped input.
- Layer 2, per j=0..N_HID, with lut_sel=0 and lut_pos=j held throughout:
  - L2_W: N_OUT reads from W2_BASE+j*N_OUT+k, with delayed r_sh_en[2].
  - L2_WD: final shift only.
  - L2_LUT:
    - j>0: mem_rd=1, mem_addr=LUT_BASE+lut_idx.
    - j=0: no read (bias).
  - L2_MAC: mac_en[1]=1.
  - Cost: 13 cycles per j.
- Output, per p=0..N_OUT-1, with lut_sel=1 and lut_pos=p:
  - O_LUT: mem_rd=1, mem_addr=LUT_BASE+lut_idx.
  - O_SH: r_sh_en[3]=1. p=0 is shifted first.
  - Cost: 2 cycles per p.
- Completion: after p=N_OUT-1 go to DONE, which pulses done and returns to IDLE.
- Busy length: T = 1 + 30·NZ + 3·Z + 13·(N_HID+1) + 2·N_OUT, where NZ = loaded inputs and Z = skipped inputs.
- Invariants:
  - At most one bit of mac_en is high.
  - mac_en and mac_clr are never high together.
  - lut_pos is stable across each LUT/MAC or LUT/SH pair.

Optional Feature:
- Macro: NN_ZERO_SKIP_EN.
- Defined: arg_zero=1 in L1_TEST skips the weight load and the MAC.
- Undefined: arg_zero is ignored and every input takes the 30-cycle path. Results are identical, since a zero argument yields a zero product.

Decomposition:
- Package nn_ctrl_pkg holds:
  - the state enum
  - N_HID/N_OUT defaults and the u-law zero code 8'hFF
  - $clog2-derived counter widths
- Sub-module nn_stream_rd: base/count address generator with a one-cycle-delayed shift enable and a last flag. It is instantiated for both the L1_W and L2_W phases.

Test Plan:
- Reset mid-L1_W (rst low for 1 cycle) → all outputs 0 immediately; no done; a new start runs a complete inference.
- N_IN=785, only the bias input nonzero, NN_ZERO_SKIP_EN defined → busy for exactly 2741 cycles, then done; exactly one mac_en[0] pulse and 26 mac_en[1] pulses.
- Same image, macro undefined → busy for 23909 cycles; 785 mac_en[0] pulses.
- Input 5 nonzero → mem_addr sequence 1149..1173 with r_sh_en[1] lagging one cycle; mac_en[0] high in the cycle after the 25th shift.
- Datapath model returns lut_idx=lut_pos+40 → layer-2 LUT reads at 32809..32833 (j=1..25), none for j=0; output reads at 32808..32817.
- start held high for the whole run → exactly one inference; a second run starts only after DONE, with IDLE sampling start.
